status_reg_stack: RTL and testbench
===================================

# status_reg_stack

Parametrised CPU status register with mode (emulation/native) handling and a hardware shadow stack that saves and restores the whole status state on interrupt entry and return. It sits in the CPU core next to the ALU flag logic and replaces the fixed 8-bit status register. It adds configurable flag width and bit positions, interrupt-entry flag forcing, and nested save/restore of up to DEPTH levels with full, empty and error reporting.

## Interface
- WIDTH, 8: status word width; must be at least 6.
- DEPTH, 4: shadow stack levels; must be at least 1.
- C_BIT, 0: flag swapped with E on exchange.
- X_BIT, 4: X in native mode, B in emulation.
- M_BIT, 5: M in native mode, reads 1 in emulation.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- cpu_en  in  1  clock enable; no state change when low.
- p  out  WIDTH  visible status word.
- e  out  1  emulation mode.
- m  out  1  native M flag.
- x  out  1  native X flag.
- wdata  in  WIDTH  write data.
- write  in  WIDTH  per-bit write enable.
- xce  in  1  exchange C_BIT with E.
- push  in  1  interrupt entry: save state, then force flags.
- pop  in  1  interrupt return: restore saved state.
- int_set  in  WIDTH  bits set to 1 on push.
- int_clr  in  WIDTH  bits cleared to 0 on push; int_clr wins over int_set.
- level  out  $clog2(DEPTH+1)  occupied stack entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- ovf  out  1  sticky: push while full.
- udf  out  1  sticky: pop while empty.
- err_clr  in  1  clears ovf and udf.

## Operation
- State: f (WIDTH-2 plain flags, all bits except M_BIT and X_BIT), m_r, x_r, b_r, e_r, DEPTH-entry stack of {e, f, m, x, b}, level.
- Output p:
  - p = f, with bit M_BIT = e ? 1 : m_r.
  - Bit X_BIT = e ? b_r : x_r.
- Reset values: f=0, m_r=1, x_r=1, b_r=0, e_r=1. Outputs: p has only M_BIT set (0x20 at defaults), e=m=x=1, level=0, empty=1, full=0, ovf=udf=0. Stack contents are don't-care.
- When cpu_en=1, exactly one action is taken, in priority order xce > pop > push > write. Lower-priority requests in the same cycle are dropped.
- xce: f[C_BIT] takes e_r and e_r takes f[C_BIT]. If the new e is 1, force m_r=x_r=1.
- pop, level>0: load f, m_r, x_r, b_r and e_r from entry level-1, then decrement level.
- pop, level==0: no state change; set udf.
- push, level<DEPTH: store the pre-update state at entry level and increment level. Then apply f' = (f | int_set) & ~int_clr to the plain flags.
- push, level==DEPTH: the stack and level are unchanged, but the int_set/int_clr update still applies. Set ovf.
- When push applies the int_set/int_clr update:
  - M_BIT and X_BIT of the masks apply to m_r/x_r only in native mode.
  - In emulation mode, X_BIT of the masks applies to b_r; M_BIT is ignored.
- write: each bit with write=1 takes wdata, otherwise it holds.
  - In emulation, the X_BIT write goes to b_r and the M_BIT write is ignored; m_r and x_r hold.
  - In native mode, the M_BIT and X_BIT writes go to m_r and x_r; b_r holds.
- Error flags:
  - err_clr clears ovf and udf. It acts independently of the other actions but only when cpu_en=1.
  - If err_clr and a new error occur in the same cycle, the set wins.

## Timing
- All outputs are registered; an action is visible on the cycle after the edge that takes it (latency 1).
- full, empty and level update on the same edge as the stack pointer.
- Back-to-back push/pop on consecutive enabled cycles is supported with no bubbles.
- cpu_en=0 holds all state, including the sticky errors; requests arriving while cpu_en=0 are lost, not queued.
- Reset mid-sequence returns to the reset values on the next edge and discards all stack entries.

## Test plan
- Reset, then write=0xFF, wdata=0x00 in emulation → p=0x20, b=0. Then xce with C=0 → e=0, C=1, p=0x31.
- Native mode (e=0), write=0x30, wdata=0x00 → m=x=0, p[5:4]=00. Then xce with C=1 → e=1, m=x=1, C=0.
- Native mode, f=0x81, push with int_set=0x04, int_clr=0x08:
  - Required: level=1, p=0x85.
  - Then pop → p=0x81, level=0, empty=1.
- DEPTH=4: five pushes → full=1 after the fourth, ovf=1 after the fifth, level stays 4. Four pops then restore states in LIFO order.
- Pop at level 0 → udf=1, p unchanged. Then err_clr → udf=0.
- xce, push and write asserted in the same cycle → only the exchange occurs, level is unchanged. With cpu_en=0, no input changes any output.

Source files
------------

// File: rtl/status_reg_stack.sv
// status_reg_stack: CPU status register with emulation/native mode handling
// and a shadow stack that saves/restores the whole status state on interrupt
// entry and return. WIDTH >= 6 and DEPTH >= 1 are expected. C_BIT, X_BIT and
// M_BIT must be distinct bit positions.
module status_reg_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int C_BIT = 0,
    parameter int X_BIT = 4,
    parameter int M_BIT = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_en,
    output logic [WIDTH-1:0]             p,
    output logic                         e,
    output logic                         m,
    output logic                         x,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [WIDTH-1:0]             write,
    input  logic                         xce,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             int_set,
    input  logic [WIDTH-1:0]             int_clr,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         udf,
    input  logic                         err_clr
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    // Plain flags live in a full-width vector; the M and X positions are kept
    // at zero because their values come from m/x/b depending on mode.
    localparam logic [WIDTH-1:0] M_ONEHOT   = WIDTH'(1) << M_BIT;
    localparam logic [WIDTH-1:0] X_ONEHOT   = WIDTH'(1) << X_BIT;
    localparam logic [WIDTH-1:0] PLAIN_MASK = ~(M_ONEHOT | X_ONEHOT);

    typedef struct packed {
        logic             e;
        logic [WIDTH-1:0] f;
        logic             m;
        logic             x;
        logic             b;
    } state_t;

    localparam state_t RESET_STATE = '{e: 1'b1, f: '0, m: 1'b1, x: 1'b1, b: 1'b0};

    state_t          cur;
    state_t          nxt;
    state_t          stack [DEPTH];
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_n;
    logic [LW-1:0]   level_dec;
    logic            ovf_r;
    logic            ovf_n;
    logic            udf_r;
    logic            udf_n;
    logic            stack_we;

    assign level_dec = level_r - LW'(1);

    // Next-state selection: one action per enabled cycle, xce > pop > push > write.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        nxt      = cur;
        level_n  = level_r;
        ovf_n    = ovf_r;
        udf_n    = udf_r;
        stack_we = 1'b0;

        if (cpu_en) begin
            // Clear first so an error raised in the same cycle overrides it.
            if (err_clr) begin
                ovf_n = 1'b0;
                udf_n = 1'b0;
            end

            if (xce) begin
                nxt.f[C_BIT] = cur.e;
                nxt.e        = cur.f[C_BIT];
                if (cur.f[C_BIT]) begin
                    nxt.m = 1'b1;
                    nxt.x = 1'b1;
                end
            end else if (pop) begin
                if (level_r != '0) begin
                    nxt     = stack[level_dec[IW-1:0]];
                    level_n = level_dec;
                end else begin
                    udf_n = 1'b1;
                end
            end else if (push) begin
                if (level_r != DEPTH_L) begin
                    stack_we = 1'b1;
                    level_n  = level_r + LW'(1);
                end else begin
                    ovf_n = 1'b1;
                end
                // Interrupt flag forcing applies even when the stack is full.
                nxt.f = ((cur.f | int_set) & ~int_clr) & PLAIN_MASK;
                if (cur.e) begin
                    nxt.b = (cur.b | int_set[X_BIT]) & ~int_clr[X_BIT];
                end else begin
                    nxt.m = (cur.m | int_set[M_BIT]) & ~int_clr[M_BIT];
                    nxt.x = (cur.x | int_set[X_BIT]) & ~int_clr[X_BIT];
                end
            end else begin
                nxt.f = ((cur.f & ~write) | (wdata & write)) & PLAIN_MASK;
                if (cur.e) begin
                    if (write[X_BIT]) nxt.b = wdata[X_BIT];
                end else begin
                    if (write[M_BIT]) nxt.m = wdata[M_BIT];
                    if (write[X_BIT]) nxt.x = wdata[X_BIT];
                end
            end
        end
    end

    // Status, stack pointer and sticky error registers; reset dominates cpu_en.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            cur     <= RESET_STATE;
            level_r <= '0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            cur     <= nxt;
            level_r <= level_n;
            ovf_r   <= ovf_n;
            udf_r   <= udf_n;
        end
    end

    // Shadow stack storage: holds the pre-update state at the current level on push.
    always_ff @(posedge clk) begin
        // NOTE: the memory is not reset; clearing level already makes every entry unreachable.
        if (!reset && stack_we) begin
            stack[level_r[IW-1:0]] <= cur;
        end
    end

    // Visible status word: M and X positions depend on the current mode.
    always_comb begin
        p        = cur.f;
        p[M_BIT] = cur.e ? 1'b1  : cur.m;
        p[X_BIT] = cur.e ? cur.b : cur.x;
    end

    assign e     = cur.e;
    assign m     = cur.m;
    assign x     = cur.x;
    assign level = level_r;
    assign full  = (level_r == DEPTH_L);
    assign empty = (level_r == '0);
    assign ovf   = ovf_r;
    assign udf   = udf_r;

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed testbench for status_reg_stack at default parameters
// (WIDTH=8, DEPTH=4, C_BIT=0, X_BIT=4, M_BIT=5).
module tb_status_reg_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_en;
    logic [7:0] p;
    logic       e;
    logic       m;
    logic       x;
    logic [7:0] wdata;
    logic [7:0] write;
    logic       xce;
    logic       push;
    logic       pop;
    logic [7:0] int_set;
    logic [7:0] int_clr;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
    logic       err_clr;

    int vectors     = 0;
    int miscompares = 0;

    status_reg_stack dut (
        .clk     (clk),
        .reset   (reset),
        .cpu_en  (cpu_en),
        .p       (p),
        .e       (e),
        .m       (m),
        .x       (x),
        .wdata   (wdata),
        .write   (write),
        .xce     (xce),
        .push    (push),
        .pop     (pop),
        .int_set (int_set),
        .int_clr (int_clr),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset   = 1'b0;
        cpu_en  = 1'b1;
        wdata   = 8'h00;
        write   = 8'h00;
        xce     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        int_set = 8'h00;
        int_clr = 8'h00;
        err_clr = 1'b0;
    endtask

    // Apply current inputs for one edge, then return inputs to idle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_write(input logic [7:0] we, input logic [7:0] wd);
        write = we;
        wdata = wd;
        step();
    endtask

    task automatic do_push(input logic [7:0] s, input logic [7:0] c);
        push    = 1'b1;
        int_set = s;
        int_clr = c;
        step();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle();

        // Reset state
        check("rst_p", p, 8'h20);
        check("rst_e", e, 1'b1);
        check("rst_m", m, 1'b1);
        check("rst_x", x, 1'b1);
        check("rst_level", level, 3'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_udf", udf, 1'b0);

        // Emulation writes: M ignored, X position goes to b
        do_write(8'hFF, 8'h00);
        check("emu_wr0_p", p, 8'h20);
        do_write(8'h10, 8'h10);
        check("emu_wr_b_p", p, 8'h30);
        check("emu_wr_b_m", m, 1'b1);
        do_write(8'h10, 8'h00);
        check("emu_wr_b0_p", p, 8'h20);

        // Exchange with C=0 enters native mode
        xce = 1'b1;
        step();
        check("xce_native_e", e, 1'b0);
        check("xce_native_p", p, 8'h31);

        // Native write clears m and x
        do_write(8'h30, 8'h00);
        check("nat_wr_m", m, 1'b0);
        check("nat_wr_x", x, 1'b0);
        check("nat_wr_p", p, 8'h01);

        // Exchange with C=1 returns to emulation and forces m=x=1
        xce = 1'b1;
        step();
        check("xce_emu_e", e, 1'b1);
        check("xce_emu_m", m, 1'b1);
        check("xce_emu_x", x, 1'b1);
        check("xce_emu_p", p, 8'h20);

        // Back to native, f = 0x81 with m=x=0
        xce = 1'b1;
        step();
        check("xce2_p", p, 8'h31);
        do_write(8'hFF, 8'h81);
        check("nat_f81_p", p, 8'h81);

        // Push with set/clr, then pop
        do_push(8'h04, 8'h08);
        check("push1_p", p, 8'h85);
        check("push1_level", level, 3'd1);
        check("push1_empty", empty, 1'b0);
        do_pop();
        check("pop1_p", p, 8'h81);
        check("pop1_level", level, 3'd0);
        check("pop1_empty", empty, 1'b1);

        // Native masks reach m/x; int_clr wins over int_set
        do_push(8'h32, 8'h02);
        check("push_mx_p", p, 8'hB1);
        check("push_mx_m", m, 1'b1);
        do_pop();
        check("pop_mx_p", p, 8'h81);
        check("pop_mx_m", m, 1'b0);

        // Fill the stack, overflow, then LIFO restore
        do_push(8'h02, 8'h00);
        check("fill1_p", p, 8'h83);
        do_push(8'h04, 8'h00);
        check("fill2_p", p, 8'h87);
        do_push(8'h08, 8'h00);
        check("fill3_p", p, 8'h8F);
        check("fill3_full", full, 1'b0);
        do_push(8'h40, 8'h00);
        check("fill4_p", p, 8'hCF);
        check("fill4_level", level, 3'd4);
        check("fill4_full", full, 1'b1);
        check("fill4_ovf", ovf, 1'b0);
        do_push(8'h10, 8'h00);
        check("ovf_p", p, 8'hDF);
        check("ovf_level", level, 3'd4);
        check("ovf_flag", ovf, 1'b1);
        do_pop();
        check("lifo1_p", p, 8'h8F);
        check("lifo1_level", level, 3'd3);
        check("lifo1_full", full, 1'b0);
        do_pop();
        check("lifo2_p", p, 8'h87);
        do_pop();
        check("lifo3_p", p, 8'h83);
        do_pop();
        check("lifo4_p", p, 8'h81);
        check("lifo4_empty", empty, 1'b1);

        // Underflow, then clear; set wins over simultaneous clear
        do_pop();
        check("udf_flag", udf, 1'b1);
        check("udf_p", p, 8'h81);
        check("udf_level", level, 3'd0);
        err_clr = 1'b1;
        step();
        check("errclr_udf", udf, 1'b0);
        check("errclr_ovf", ovf, 1'b0);
        pop     = 1'b1;
        err_clr = 1'b1;
        step();
        check("setwins_udf", udf, 1'b1);
        err_clr = 1'b1;
        step();
        check("errclr2_udf", udf, 1'b0);

        // xce + push + write: only exchange happens
        xce   = 1'b1;
        push  = 1'b1;
        write = 8'hFF;
        wdata = 8'hFF;
        step();
        check("prio_p", p, 8'hA0);
        check("prio_e", e, 1'b1);
        check("prio_level", level, 3'd0);

        // Emulation push: X mask goes to b, M mask ignored
        do_push(8'h30, 8'h20);
        check("emu_push_p", p, 8'hB0);
        check("emu_push_m", m, 1'b1);
        // pop beats push and write
        pop   = 1'b1;
        push  = 1'b1;
        write = 8'hFF;
        wdata = 8'h00;
        step();
        check("pop_prio_p", p, 8'hA0);
        check("pop_prio_level", level, 3'd0);

        // cpu_en low freezes everything, including sticky errors
        do_pop();
        check("udf_again", udf, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cpu_en  = 1'b0;
            xce     = 1'b1;
            push    = 1'b1;
            write   = 8'hFF;
            wdata   = 8'h00;
            err_clr = 1'b1;
            step();
        end
        check("hold_p", p, 8'hA0);
        check("hold_e", e, 1'b1);
        check("hold_level", level, 3'd0);
        check("hold_udf", udf, 1'b1);
        step();
        check("lost_p", p, 8'hA0);
        check("lost_level", level, 3'd0);

        // Mid-sequence reset discards the stack
        do_push(8'h01, 8'h00);
        check("pre_rst_level", level, 3'd1);
        reset = 1'b1;
        push  = 1'b1;
        step();
        check("mid_rst_p", p, 8'h20);
        check("mid_rst_level", level, 3'd0);
        check("mid_rst_udf", udf, 1'b0);
        check("mid_rst_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
